mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between two requesters: instruction fetch (IF) and the MEM-stage data access (DM).
- Sits between the pipeline and the memory macro; the core stalls on the deasserted ready signals.
- One transaction is in flight at a time.
- Data side has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between instruction fetch and data access.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              dm_req_valid,
    input  logic              dm_req_we,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic [DATA_W-1:0] dm_req_wdata,
    output logic              dm_req_ready,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_grants
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);

    logic [1:0]        state;
    logic [SW-1:0]     starve_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              owner_dm;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] if_hold_q;
    logic [DATA_W-1:0] dm_hold_q;
    logic              grant_if;
    logic              grant_dm;

    // Readies are held low while reset is asserted so nothing can be accepted into a reset cycle.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE && rst_n) begin
            if (starve_cnt == STARVE_TOP && if_req_valid) begin
                grant_if = 1'b1;
            end else if (dm_req_valid) begin
                grant_dm = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;
    assign busy         = (state != IDLE);
    assign mem_en       = (state == ISSUE);
    assign mem_we       = mem_en & we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_rsp_valid = (state == RESP) & ~owner_dm;
    assign dm_rsp_valid = (state == RESP) & owner_dm;
    // Hold registers keep the data outputs stable between pulses.
    assign if_rsp_data  = if_rsp_valid ? rsp_data_q : if_hold_q;
    assign dm_rsp_data  = dm_rsp_valid ? rsp_data_q : dm_hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            if_hold_q  <= '0;
            dm_hold_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        owner_dm <= grant_dm;
                        addr_q   <= grant_dm ? dm_req_addr : if_req_addr;
                        we_q     <= grant_dm & dm_req_we;
                        wdata_q  <= grant_dm ? dm_req_wdata : '0;
                        state    <= ISSUE;
                        if (grant_if) begin
                            starve_cnt <= '0;
                        end else if (if_req_valid && starve_cnt != STARVE_TOP) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_data_q <= we_q ? '0 : mem_rdata;
                        state      <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                default: begin
                    if (owner_dm) begin
                        dm_hold_q <= rsp_data_q;
                    end else begin
                        if_hold_q <= rsp_data_q;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_wait   <= '0;
            perf_dm_grants <= '0;
        end else begin
            if (if_req_valid && !if_req_ready) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (grant_dm) begin
                perf_dm_grants <= perf_dm_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance a (MEM_LAT=1, STARVE_MAX=2), instance b (MEM_LAT=3).
// Define ARB_PERF_CNT_EN to also check the performance counters on instance b.
module tb_mem_port_arbiter;

    typedef struct {
        logic        dm;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n_a, if_valid_a, if_ready_a, if_rsp_valid_a, dm_valid_a, dm_we_a, dm_ready_a, dm_rsp_valid_a;
    logic        mem_en_a, mem_we_a, busy_a;
    logic [31:0] if_addr_a, if_rsp_data_a, dm_addr_a, dm_wdata_a, dm_rsp_data_a, mem_addr_a, mem_wdata_a, rdata_a;
    logic        rst_n_b, if_valid_b, if_ready_b, if_rsp_valid_b, dm_valid_b, dm_we_b, dm_ready_b, dm_rsp_valid_b;
    logic        mem_en_b, mem_we_b, busy_b;
    logic [31:0] if_addr_b, if_rsp_data_b, dm_addr_b, dm_wdata_b, dm_rsp_data_b, mem_addr_b, mem_wdata_b, rdata_b;
    logic [31:0] p1_b, p2_b;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] pw_a, pg_a, pw_b, pg_b;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) u_a (
        .clk(clk), .rst_n(rst_n_a),
        .if_req_valid(if_valid_a), .if_req_addr(if_addr_a), .if_req_ready(if_ready_a),
        .if_rsp_valid(if_rsp_valid_a), .if_rsp_data(if_rsp_data_a),
        .dm_req_valid(dm_valid_a), .dm_req_we(dm_we_a), .dm_req_addr(dm_addr_a),
        .dm_req_wdata(dm_wdata_a), .dm_req_ready(dm_ready_a),
        .dm_rsp_valid(dm_rsp_valid_a), .dm_rsp_data(dm_rsp_data_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(rdata_a), .busy(busy_a)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_wait(pw_a), .perf_dm_grants(pg_a)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
        .clk(clk), .rst_n(rst_n_b),
        .if_req_valid(if_valid_b), .if_req_addr(if_addr_b), .if_req_ready(if_ready_b),
        .if_rsp_valid(if_rsp_valid_b), .if_rsp_data(if_rsp_data_b),
        .dm_req_valid(dm_valid_b), .dm_req_we(dm_we_b), .dm_req_addr(dm_addr_b),
        .dm_req_wdata(dm_wdata_b), .dm_req_ready(dm_ready_b),
        .dm_rsp_valid(dm_rsp_valid_b), .dm_rsp_data(dm_rsp_data_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(rdata_b), .busy(busy_b)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_wait(pw_b), .perf_dm_grants(pg_b)
`endif
    );

    // Fixed memory image; data outside the valid slot is garbage so mistimed captures show up.
    function automatic logic [31:0] rd(input logic [31:0] a);
        case (a)
            32'h10:  rd = 32'h0051_0113;
            32'h14:  rd = 32'h00A0_0093;
            32'h20:  rd = 32'h55AA_55AA;
            32'h30:  rd = 32'h0BAD_F00D;
            32'h40:  rd = 32'h1234_5678;
            default: rd = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(posedge clk) rdata_a <= mem_en_a ? rd(mem_addr_a) : 32'hCCCC_CCCC;
    always @(posedge clk) begin
        p1_b    <= mem_en_b ? rd(mem_addr_b) : 32'hCCCC_CCCC;
        p2_b    <= p1_b;
        rdata_b <= p2_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic dm, input logic [31:0] d, input int c);
        exp_t e;
        e.dm = dm; e.data = d; e.cyc = c;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic mon(input int i, input logic ifv, input logic dmv, input logic [31:0] ifd, input logic [31:0] dmd);
        exp_t e;
        string t;
        t = (i == 0) ? "a" : "b";
        if (!(ifv || dmv)) return;
        chk({t, "_rsp_exclusive"}, 32'(ifv && dmv), 32'd0);
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_rsp actual if=%0b dm=%0b required none, cycle=%0d", t, ifv, dmv, cyc);
            return;
        end
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk({t, "_rsp_port"}, 32'(dmv), 32'(e.dm));
        chk({t, "_rsp_data"}, dmv ? dmd : ifd, e.data);
        chk({t, "_rsp_cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        mon(0, if_rsp_valid_a, dm_rsp_valid_a, if_rsp_data_a, dm_rsp_data_a);
        mon(1, if_rsp_valid_b, dm_rsp_valid_b, if_rsp_data_b, dm_rsp_data_b);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int k;
        int last;
        logic g_dm;
        logic exp_dm [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   exp_st [6]  = '{0, 1, 2, 0, 1, 2};
        rst_n_a = 0; rst_n_b = 0;
        if_valid_a = 0; if_addr_a = 0; dm_valid_a = 0; dm_we_a = 0; dm_addr_a = 0; dm_wdata_a = 0;
        if_valid_b = 0; if_addr_b = 0; dm_valid_b = 0; dm_we_b = 0; dm_addr_b = 0; dm_wdata_b = 0;
        step();
        step();
        if_valid_a = 1; if_addr_a = 32'h10;
        @(negedge clk);
        chk("reset_if_ready", 32'(if_ready_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_mem_en", 32'(mem_en_a), 0);
        chk("reset_if_rsp_data", if_rsp_data_a, 0);

        // IF read alone
        step();
        rst_n_a = 1; rst_n_b = 1;
        @(negedge clk);
        chk("t1_if_ready", 32'(if_ready_a), 1);
        chk("t1_dm_ready", 32'(dm_ready_a), 0);
        push(0, 1'b0, 32'h0051_0113, cyc + 3);
        step();
        if_valid_a = 0;
        @(negedge clk);
        chk("t1_mem_en", 32'(mem_en_a), 1);
        chk("t1_mem_addr", mem_addr_a, 32'h10);
        chk("t1_mem_we", 32'(mem_we_a), 0);
        chk("t1_busy", 32'(busy_a), 1);
        repeat (4) step();

        // DM write wins over IF, then IF follows
        dm_valid_a = 1; dm_we_a = 1; dm_addr_a = 32'h20; dm_wdata_a = 32'hDEAD_BEEF;
        if_valid_a = 1; if_addr_a = 32'h14;
        @(negedge clk);
        chk("t2_dm_ready", 32'(dm_ready_a), 1);
        chk("t2_if_ready", 32'(if_ready_a), 0);
        push(0, 1'b1, 32'h0, cyc + 3);
        n = cyc;
        step();
        dm_valid_a = 0; dm_we_a = 0;
        @(negedge clk);
        chk("t2_mem_we", 32'(mem_we_a), 1);
        chk("t2_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
        chk("t2_mem_addr", mem_addr_a, 32'h20);
        chk("t2_readies_busy", {30'd0, if_ready_a, dm_ready_a}, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (if_ready_a) break;
        end
        chk("t2_if_grant_cycle", 32'(cyc), 32'(n + 4));
        if (if_ready_a) push(0, 1'b0, 32'h00A0_0093, cyc + 3);
        step();
        if_valid_a = 0;
        repeat (5) step();

        // Starvation: both requesters valid continuously
        dm_valid_a = 1; dm_addr_a = 32'h30; if_valid_a = 1; if_addr_a = 32'h10;
        k = 0; last = 0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (if_ready_a || dm_ready_a) begin
                g_dm = dm_ready_a;
                chk("t3_single_ready", 32'(if_ready_a && dm_ready_a), 0);
                chk("t3_grant_id", 32'(g_dm), 32'(exp_dm[k]));
                chk("t3_starve_cnt", 32'(u_a.starve_cnt), 32'(exp_st[k]));
                if (k > 0) chk("t3_grant_spacing", 32'(cyc - last), 4);
                push(0, g_dm, g_dm ? 32'h0BAD_F00D : 32'h0051_0113, cyc + 3);
                last = cyc;
                k++;
            end
        end
        chk("t3_grant_count", 32'(k), 6);
        step();
        dm_valid_a = 0; if_valid_a = 0;
        repeat (5) step();

        // Reset during WAIT aborts the IF read
        if_valid_a = 1; if_addr_a = 32'h14;
        @(negedge clk);
        chk("t4_if_ready", 32'(if_ready_a), 1);
        step();
        if_valid_a = 0;
        step();
        rst_n_a = 0;
        step();
        rst_n_a = 1;
        dm_valid_a = 1; dm_we_a = 0; dm_addr_a = 32'h30;
        @(negedge clk);
        chk("t4_busy_after_reset", 32'(busy_a), 0);
        chk("t4_mem_en_after_reset", 32'(mem_en_a), 0);
        chk("t4_dm_ready_after_reset", 32'(dm_ready_a), 1);
        push(0, 1'b1, 32'h0BAD_F00D, cyc + 3);
        step();
        dm_valid_a = 0;
        repeat (5) step();

        // MEM_LAT=3: DM read with IF blocked behind it
        dm_valid_b = 1; dm_addr_b = 32'h40; if_valid_b = 1; if_addr_b = 32'h10;
        @(negedge clk);
        chk("t5_dm_ready", 32'(dm_ready_b), 1);
        chk("t5_if_ready", 32'(if_ready_b), 0);
        push(1, 1'b1, 32'h1234_5678, cyc + 5);
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 1) dm_valid_b = 0;
            @(negedge clk);
            chk($sformatf("t5_busy_%0d", j), 32'(busy_b), 32'(j <= 5));
            chk($sformatf("t5_mem_en_%0d", j), 32'(mem_en_b), 32'(j == 1));
            chk($sformatf("t5_if_ready_%0d", j), 32'(if_ready_b), 32'(j == 6));
            if (j == 6 && if_ready_b) push(1, 1'b0, 32'h0051_0113, cyc + 5);
        end
        step();
        if_valid_b = 0;
        @(negedge clk);
`ifdef ARB_PERF_CNT_EN
        chk("t6_perf_if_wait", pw_b, 32'd6);
        chk("t6_perf_dm_grants", pg_b, 32'd1);
`endif
        repeat (8) step();
        chk("a_queue_drained", 32'(q0.size()), 0);
        chk("b_queue_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
